ysyx_22040931_ifu: RTL
======================

Name: ysyx_22040931_ifu

Overview:
- Instruction fetch unit.
- Consumes the jump redirect produced by the J-type/branch decode path and turns it into PC updates.
- Issues fetch requests to instruction memory over a valid/ready channel and hands fetched instructions to decode over a second valid/ready channel.
- Sits between the instruction memory port and the decode stage; the only block that owns the architectural fetch PC.

Parameters:
- ADDR_W, 64, width of PC and memory address.
- RESET_PC, 64'h8000_0000, first fetch address after reset.

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- jump_valid  in  1  redirect request (jal taken / branch taken), single-cycle pulse or held
- jump_target  in  ADDR_W  redirect destination PC
- imem_req_valid  out  1  fetch request valid
- imem_req_ready  in  1  memory accepts request
- imem_req_addr  out  ADDR_W  fetch address, stable while imem_req_valid && !imem_req_ready
- imem_resp_valid  in  1  fetched word valid
- imem_resp_data  in  32  fetched instruction word
- imem_resp_ready  out  1  IFU accepts response
- inst_valid  out  1  instruction to decode valid
- inst_ready  in  1  decode accepts instruction
- inst  out  32  instruction word
- inst_pc  out  ADDR_W  PC of inst

Behaviour:
- Reset (async, rst=1):
  - pc=RESET_PC, state=REQ, drop=0.
  - imem_req_valid=0 during reset and 1 from the first cycle after deassertion.
  - imem_resp_ready=0, inst_valid=0, inst=0, inst_pc=0.
- FSM states: REQ, WAIT, OUT.
- REQ:
  - imem_req_valid=1, imem_req_addr=pc.
  - On imem_req_ready: go to WAIT.
- WAIT:
  - imem_resp_ready=1.
  - On imem_resp_valid with drop=0: latch inst=imem_resp_data and inst_pc=pc, then go to OUT.
  - On imem_resp_valid with drop=1: discard the data, clear drop, go to REQ (pc already holds the redirect target).
- OUT:
  - inst_valid=1; inst and inst_pc are held stable until the handshake.
  - On inst_ready: pc=pc+4 (wrap modulo 2^ADDR_W), inst_valid=0 next cycle, go to REQ.
  - Fetch-to-decode latency: 2 cycles minimum (REQ accept cycle, WAIT response cycle), plus memory wait cycles.
- Redirect (jump_valid=1), sampled every cycle, highest priority:
  - REQ, request not yet accepted (imem_req_ready=0): pc=jump_target; next cycle addr switches to the target. A request may change address only while unaccepted; this is the one sanctioned exception.
  - REQ, same cycle as imem_req_ready=1: the request at the old pc is accepted; pc=jump_target, drop=1, go to WAIT.
  - WAIT, no response this cycle: pc=jump_target, drop=1.
  - WAIT, same cycle as imem_resp_valid: response discarded, pc=jump_target, drop=0, go to REQ.
  - OUT, regardless of inst_ready: inst_valid=0 next cycle, the held instruction is discarded (decode must ignore a handshake coincident with a redirect), pc=jump_target, go to REQ.
  - Redirect held for several cycles: each cycle reloads the same target. No duplicate in-flight requests; at most one outstanding fetch at any time.
- Back-to-back redirects while drop=1: pc updates to the newest target and drop stays 1.
- Reset mid-transaction: state returns to REQ immediately. A memory response arriving after reset while in REQ is ignored (imem_resp_ready=0).
- Memory request and response handshakes are never both pending; no response is accepted outside WAIT.

Optional Feature:
- Macro: YSYX_22040931_IFU_MISALIGN_CHK_EN.
- Defined:
  - Adds output inst_misalign (1 bit).
  - A redirect with jump_target[1:0]!=0 skips the fetch: the FSM goes straight to OUT with inst=32'h0000_0013 (nop), inst_pc=jump_target, inst_misalign=1.
  - inst_misalign is cleared on the OUT handshake or a redirect.
  - pc advances by +4 from the misaligned value.
- Undefined:
  - No port.
  - Target bits [1:0] are forced to 0 before loading pc.

Test Plan:
- Reset release, memory ready=1, 1-cycle response -> req addrs 0x80000000, 0x80000004, 0x80000008; inst_pc matches each; inst equals returned data.
- inst_ready held 0 for 5 cycles in OUT -> inst_valid, inst and inst_pc stable; no new imem request issued.
- jump_valid with target 0x80001000 during WAIT, response arrives 3 cycles later -> response dropped, inst_valid stays 0, next req addr 0x80001000.
- jump_valid with target 0x80002000 coincident with the OUT handshake -> instruction invalidated, next req addr 0x80002000 (not pc+4).
- pc=0xFFFF_FFFF_FFFF_FFFC with ADDR_W=64 after a handshake -> next req addr 0x0.
- Macro defined, jump_target=0x80000002 -> inst_valid with inst_misalign=1, inst=0x00000013, no imem request for that PC; macro undefined -> req addr 0x80000000.

Source files
------------

// File: rtl/ysyx_22040931_ifu.sv
// ----------------------------------------------------------------------------
// ysyx_22040931_ifu : instruction fetch unit
//
// Owns the architectural fetch PC. Issues one fetch at a time to instruction
// memory, hands the returned word to decode, and applies jump/branch
// redirects, which take priority over everything else in every state.
//
// Ports
//   clk, rst                 clock, asynchronous active-high reset
//   jump_valid, jump_target  redirect request and destination PC
//   imem_req_*               fetch request channel (valid/ready, addr)
//   imem_resp_*              fetch response channel (valid/ready, data)
//   inst_valid/ready         instruction channel to decode
//   inst, inst_pc            instruction word and its PC
//   inst_misalign            (optional) instruction is a nop standing in for
//                            a misaligned redirect target
//
// Optional feature macro: YSYX_22040931_IFU_MISALIGN_CHK_EN
//   defined   : a misaligned redirect target is not fetched; a nop carrying
//               that PC is handed to decode with inst_misalign=1.
//   undefined : redirect target bits [1:0] are forced to zero.
// ----------------------------------------------------------------------------
module ysyx_22040931_ifu #(
  parameter int unsigned       ADDR_W   = 64,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(64'h8000_0000)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              jump_valid,
  input  logic [ADDR_W-1:0] jump_target,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [ADDR_W-1:0] imem_req_addr,
  input  logic              imem_resp_valid,
  input  logic [31:0]       imem_resp_data,
  output logic              imem_resp_ready,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [31:0]       inst,
  output logic [ADDR_W-1:0] inst_pc
`ifdef YSYX_22040931_IFU_MISALIGN_CHK_EN
  ,
  output logic              inst_misalign
`endif
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {S_REQ, S_WAIT, S_OUT} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] inst_pc_q, inst_pc_d;
  logic [31:0]       inst_q, inst_d;
  logic              drop_q, drop_d;
  logic              mis_q, mis_d;
  logic              req_valid_q, resp_ready_q, inst_valid_q;

  logic [ADDR_W-1:0] tgt;
  logic              tgt_mis;  // redirect target needs a synthesized nop
  logic              pc_mis;   // pending (dropped-fetch) target needs a nop

`ifdef YSYX_22040931_IFU_MISALIGN_CHK_EN
  assign tgt     = jump_target;
  assign tgt_mis = |jump_target[1:0];
  assign pc_mis  = |pc_q[1:0];
  assign inst_misalign = mis_q;
`else
  logic unused_tgt_lo;
  logic unused_mis;
  assign tgt           = {jump_target[ADDR_W-1:2], 2'b00};
  assign tgt_mis       = 1'b0;
  assign pc_mis        = 1'b0;
  assign unused_tgt_lo = ^jump_target[1:0];
  assign unused_mis    = mis_q;
`endif

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    drop_d    = drop_q;
    inst_d    = inst_q;
    inst_pc_d = inst_pc_q;
    mis_d     = mis_q;
    unique case (state_q)
      S_REQ: begin
        if (jump_valid) begin
          pc_d = tgt;
          if (imem_req_ready) begin
            // The old-pc request is accepted this cycle; swallow its response.
            drop_d  = 1'b1;
            state_d = S_WAIT;
          end else if (tgt_mis) begin
            inst_d    = NOP;
            inst_pc_d = tgt;
            mis_d     = 1'b1;
            state_d   = S_OUT;
          end
        end else if (imem_req_ready) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (jump_valid) begin
          pc_d = tgt;
          if (imem_resp_valid) begin
            // Response consumed and discarded now, nothing left in flight.
            drop_d = 1'b0;
            if (tgt_mis) begin
              inst_d    = NOP;
              inst_pc_d = tgt;
              mis_d     = 1'b1;
              state_d   = S_OUT;
            end else begin
              state_d = S_REQ;
            end
          end else begin
            drop_d = 1'b1;
          end
        end else if (imem_resp_valid) begin
          if (drop_q) begin
            // pc already holds the redirect target.
            drop_d = 1'b0;
            if (pc_mis) begin
              inst_d    = NOP;
              inst_pc_d = pc_q;
              mis_d     = 1'b1;
              state_d   = S_OUT;
            end else begin
              state_d = S_REQ;
            end
          end else begin
            inst_d    = imem_resp_data;
            inst_pc_d = pc_q;
            mis_d     = 1'b0;
            state_d   = S_OUT;
          end
        end
      end
      S_OUT: begin
        if (jump_valid) begin
          // Held instruction is dropped even if decode handshakes this cycle.
          pc_d  = tgt;
          mis_d = 1'b0;
          if (tgt_mis) begin
            inst_d    = NOP;
            inst_pc_d = tgt;
            mis_d     = 1'b1;
          end else begin
            state_d = S_REQ;
          end
        end else if (inst_ready) begin
          pc_d    = pc_q + ADDR_W'(4);
          mis_d   = 1'b0;
          state_d = S_REQ;
        end
      end
      default: state_d = S_REQ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_REQ;
      pc_q         <= RESET_PC;
      drop_q       <= 1'b0;
      mis_q        <= 1'b0;
      inst_q       <= '0;
      inst_pc_q    <= '0;
      req_valid_q  <= 1'b0;
      resp_ready_q <= 1'b0;
      inst_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      drop_q       <= drop_d;
      mis_q        <= mis_d;
      inst_q       <= inst_d;
      inst_pc_q    <= inst_pc_d;
      // Channel strobes are registered decodes of the next state.
      req_valid_q  <= (state_d == S_REQ);
      resp_ready_q <= (state_d == S_WAIT);
      inst_valid_q <= (state_d == S_OUT);
    end
  end

  assign imem_req_valid  = req_valid_q;
  assign imem_req_addr   = pc_q;
  assign imem_resp_ready = resp_ready_q;
  assign inst_valid      = inst_valid_q;
  assign inst            = inst_q;
  assign inst_pc         = inst_pc_q;

endmodule
